// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the stream UART transmitter.
//   - parity mode constants (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - transmitter FSM state encoding
//   - uart_frame_len(): number of UART bit periods in one frame
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // ST_BREAK / ST_HOLD are only reachable when the line-break option is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_HOLD
  } uart_state_e;

  // Bit periods per frame: start + data + optional parity + stop.
  function automatic int uart_frame_len(input int data_bits, input int parity_mode,
                                        input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with show-ahead read (dout is the head
// word whenever empty is low).
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write din when push is high and the FIFO is not full
//   pop, dout    discard the head word when pop is high and not empty
//   full, empty  occupancy flags
//   count        number of stored words (0..DEPTH)
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter fed by a valid/ready stream
// through an internal FIFO. Frames are sent back-to-back with no idle gap.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tx_break      (only with UART_TX_BREAK_EN) hold the line low while idle
//   s_valid       input word valid
//   s_ready       FIFO can accept a word (low while rst is high)
//   s_data        word to send, LSB transmitted first
//   tx            serial line, idles high, always driven from a flop
//   tx_busy       high whenever the FSM is not idle
//   fifo_count    number of queued words
// Optional feature macro: UART_TX_BREAK_EN (adds the tx_break input).
module uart_tx_stream #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_TX_BREAK_EN
  input  logic                        tx_break,
`endif
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_BITS-1:0]        s_data,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_e          state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 shift;
  logic                 tick_done;
  logic                 stop_done;
  logic                 brk;

`ifdef UART_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
  endfunction

  assign s_ready   = !fifo_full && !rst;
  assign tick_done = (tick == TICK_MAX);
  assign stop_done = (bit_cnt == STOP_LAST);

  uart_sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .din   (s_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A word is taken either from idle or on the last stop-bit cycle, so the
  // next start bit follows the stop bit with no gap. A pending break wins.
  always_comb begin
    pop   = 1'b0;
    shift = 1'b0;
    case (state)
      ST_IDLE:  pop   = !fifo_empty && !brk;
      ST_STOP:  pop   = tick_done && stop_done && !fifo_empty && !brk;
      ST_START: shift = tick_done;
      ST_DATA:  shift = tick_done && (bit_cnt != DATA_LAST);
      default: begin
        pop   = 1'b0;
        shift = 1'b0;
      end
    endcase
  end

  // Shift register and parity: loaded on pop, shifted as each bit is issued.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= fifo_dout;
      par_bit <= calc_parity(fifo_dout);
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

  // Control FSM: tx is updated on the same edge as the state so that each
  // bit starts exactly when its state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (brk) begin
            state   <= ST_BREAK;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end else if (!fifo_empty) begin
            state   <= ST_START;
            tx      <= 1'b0;
            tick    <= '0;
            tx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_done) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            tick    <= '0;
            bit_cnt <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_done) begin
            tick <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick_done) begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            tick    <= '0;
            bit_cnt <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_done) begin
            tick <= '0;
            if (stop_done) begin
              bit_cnt <= '0;
              if (brk) begin
                state <= ST_BREAK;
                tx    <= 1'b0;
              end else if (!fifo_empty) begin
                state <= ST_START;
                tx    <= 1'b0;
              end else begin
                state   <= ST_IDLE;
                tx      <= 1'b1;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_BREAK: begin
          if (!brk) begin
            state <= ST_HOLD;
            tx    <= 1'b1;
            tick  <= '0;
          end
        end
        // One full bit period of idle-high after a break before any frame.
        ST_HOLD: begin
          if (brk) begin
            state <= ST_BREAK;
            tx    <= 1'b0;
          end else if (tick_done) begin
            state   <= ST_IDLE;
            tick    <= '0;
            tx_busy <= 1'b0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Parametrised UART transmitter, successor to the fixed 8-bit TX.
- Configurable data width, parity mode, stop bits and bit-period (oversample) length.
- Accepts bytes over a valid/ready stream into an internal FIFO, so producers can queue several words.
- Sends frames back-to-back with no idle gap; sits between the system logic and the board TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- OVERSAMPLE, 16: clk cycles per UART bit; must match the RX oversample ratio; minimum 2.
- FIFO_DEPTH, 4: number of queued words; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  FIFO can accept a word; equals count < FIFO_DEPTH and not rst.
- s_data  in  DATA_BITS  word to send.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high whenever FSM is not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words queued.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-frame:
  - tx=1, tx_busy=0, FIFO emptied, fifo_count=0, FSM=IDLE, bit and tick counters cleared.
  - s_ready=0 while rst is high.
- Push: a word is accepted on a posedge with s_valid && s_ready. s_data is sampled only then; the producer may change it afterwards.
- Push and pop in the same cycle: count unchanged. At full, s_ready=0, so no push occurs.
- FSM states:
  - IDLE -> START: at a posedge where the FIFO is non-empty. The word is popped into the shift register, tx<=0, tick counter<=0. The first start-bit cycle is therefore one clk after the FIFO becomes non-empty.
  - START -> DATA: after OVERSAMPLE cycles.
  - DATA: shifts LSB first, data[0] first. Each bit is held exactly OVERSAMPLE cycles. After DATA_BITS bits, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: one bit. Odd mode sends ~^data; even mode sends ^data. Then go to STOP.
  - STOP: tx=1 for STOP_BITS*OVERSAMPLE cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
- Frame length is OVERSAMPLE*(1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) cycles exactly.
- Every bit transition on tx is registered: no combinational path from s_data or s_valid to tx.
- Tick counter width is $clog2(OVERSAMPLE). Bit counter wraps only via the state change, never by overflow.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined, adds input tx_break (1 bit):
  - While tx_break is high and the FSM is in IDLE, tx is driven 0 (line break) and FIFO pops are suspended. tx_busy=1 during the break.
  - Asserting tx_break mid-frame does not corrupt the current frame. The break begins after that frame's stop bits complete.
  - On deassertion, tx returns to 1 on the next posedge. Queued words resume after at least one full OVERSAMPLE period of idle high.
- When undefined: no tx_break port, and behaviour is exactly as described above.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PARITY_NONE/ODD/EVEN;
  - the FSM state enum;
  - the function uart_frame_len(data_bits, parity_mode, stop_bits).
- One sub-module, uart_sync_fifo (DATA width, DEPTH; push/pop/full/empty/count, async active-high rst). The FSM stays in the top.

Test Plan:
- 8N1, OVERSAMPLE=16, push 0x55:
  - tx low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16.
  - tx_busy high for exactly 160 cycles.
- PARITY_MODE=1 with 0x07 -> parity bit 0. PARITY_MODE=2 with 0x07 -> parity bit 1. PARITY_MODE=2 with 0x00 -> parity bit 0.
- DATA_BITS=7, STOP_BITS=2, push 0x41 -> 7 data bits LSB first, then tx high for 32 cycles; total frame 160 cycles.
- Push 5 words back-to-back with FIFO_DEPTH=4, drain blocked by the first frame:
  - s_ready drops when fifo_count=4.
  - Frames follow with no idle cycle between the last stop bit and the next start bit.
- Assert rst mid-data-bit of the second frame:
  - tx=1 and fifo_count=0 in the same cycle.
  - After release, a new push is sent correctly.
- With UART_TX_BREAK_EN, assert tx_break mid-frame:
  - The frame completes, then tx=0 for the duration of tx_break.
  - After release, at least 16 cycles high before the next queued start bit.
